// File: rtl/call_return_ctrl.sv
// CALL/RET sequencer in front of the return-address stack: drives push/pop and
// PC-load strobes, tracks stack depth and flags refused overflow/underflow ops.
module call_return_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               i_call,
    input  logic               i_ret,
    input  logic [ADDR_W-1:0]  i_target,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic [ADDR_W-1:0]  i_stack_data,
    input  logic               i_clr_err,
    output logic               o_push,
    output logic               o_pop,
    output logic [ADDR_W-1:0]  o_push_data,
    output logic               o_pc_load,
    output logic [ADDR_W-1:0]  o_pc_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [DEPTH_W-1:0] o_depth,
    output logic               o_overflow,
    output logic               o_underflow
);

    typedef enum logic [2:0] {
        IDLE, CALL_PUSH, CALL_JUMP, RET_LOAD, RET_POP
    } state_e;

    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

    state_e              state_q, state_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [ADDR_W-1:0]   ret_addr_q, ret_addr_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            depth_q    <= '0;
            ret_addr_q <= '0;
            target_q   <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            ret_addr_q <= ret_addr_d;
            target_q   <= target_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Clear is applied first so a fault raised on the same edge wins.
    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        ret_addr_d = ret_addr_q;
        target_d   = target_q;
        done_d     = 1'b0;
        ovf_d      = i_clr_err ? 1'b0 : ovf_q;
        unf_d      = i_clr_err ? 1'b0 : unf_q;
        unique case (state_q)
            IDLE: begin
                if (i_call) begin
                    target_d   = i_target;
                    ret_addr_d = i_pc + ADDR_W'(1);
                    if (depth_q == FULL) ovf_d = 1'b1;
                    else                 state_d = CALL_PUSH;
                end else if (i_ret) begin
                    if (depth_q == '0) unf_d = 1'b1;
                    else               state_d = RET_LOAD;
                end
            end
            CALL_PUSH: begin
                depth_d = depth_q + DEPTH_W'(1);
                state_d = CALL_JUMP;
            end
            CALL_JUMP: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            RET_LOAD: state_d = RET_POP;
            RET_POP: begin
                depth_d = depth_q - DEPTH_W'(1);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_push      = (state_q == CALL_PUSH);
        o_pop       = (state_q == RET_POP);
        o_pc_load   = (state_q == CALL_JUMP) || (state_q == RET_LOAD);
        o_push_data = o_push ? ret_addr_q : '0;
        o_pc_data   = '0;
        if (state_q == CALL_JUMP)     o_pc_data = target_q;
        else if (state_q == RET_LOAD) o_pc_data = i_stack_data;
    end

    assign o_busy      = (state_q != IDLE);
    assign o_done      = done_q;
    assign o_depth     = depth_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule

// File: doc/call_return_ctrl.md
Name: call_return_ctrl

Overview:
- Sequencer directly upstream of the hardware return-address Stack in the SAP2 core.
- Accepts CALL and RET requests from the control unit and drives the Stack's push and pop strobes and push data.
- Issues PC load strobes and PC data to the program counter.
- Tracks stack depth, refuses operations that would overflow or underflow, and reports those faults with sticky flags.

Parameters:
- ADDR_W, 16, width of PC, return addresses and Stack entries; must equal the Stack's STACK_WIDTH.
- STACK_DEPTH, 16, Stack capacity in entries; must equal the Stack's STACK_DEPTH.
- DEPTH_W, $clog2(STACK_DEPTH+1), width of the depth counter (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  global step enable; state, counters and flags change only on edges where clk_en=1.
- i_call  in  1  CALL request level; sampled in IDLE.
- i_ret  in  1  RET request level; sampled in IDLE.
- i_target  in  ADDR_W  CALL destination; sampled with i_call.
- i_pc  in  ADDR_W  current PC; sampled with i_call.
- i_stack_data  in  ADDR_W  top-of-stack value from the Stack's o_data.
- i_clr_err  in  1  clears the sticky fault flags.
- o_push  out  1  Stack push strobe.
- o_pop  out  1  Stack pop strobe.
- o_push_data  out  ADDR_W  return address presented to the Stack.
- o_pc_load  out  1  PC load strobe.
- o_pc_data  out  ADDR_W  value to load into the PC.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_done  out  1  one-cycle pulse when a CALL or RET completes.
- o_depth  out  DEPTH_W  current number of valid entries.
- o_overflow  out  1  sticky: a CALL was refused because the stack was full.
- o_underflow  out  1  sticky: a RET was refused because the stack was empty.

Behaviour:
- Reset (async, rst=1): state=IDLE; depth=0; ret_addr/target registers=0; o_overflow=o_underflow=0; o_done=0.
  - All strobes are 0 while in IDLE.
  - Reset mid-sequence aborts it immediately with no further strobes.
  - The Stack has no reset, so rst must be applied only at power-up or together with a Stack re-initialisation; depth always restarts at 0.
- FSM states: IDLE, CALL_PUSH, CALL_JUMP, RET_LOAD, RET_POP.
  - Transitions occur only on edges where clk_en=1; with clk_en=0 the state, outputs and registers hold.
- Strobe decoding:
  - o_push, o_pop and o_pc_load are Moore outputs decoded from state; none depends combinationally on clk_en.
  - The Stack and PC act on the same clk_en edge that advances the FSM.
- IDLE, i_call=1:
  - Latch target=i_target and ret_addr=i_pc+1 (mod 2^ADDR_W; 0xFFFF+1 wraps to 0x0000).
  - If depth==STACK_DEPTH: set o_overflow, stay in IDLE, no strobes, no o_done.
  - Otherwise go to CALL_PUSH.
- IDLE, i_ret=1 and i_call=0:
  - If depth==0: set o_underflow, stay in IDLE.
  - Otherwise go to RET_LOAD.
- i_call and i_ret both high in IDLE: CALL takes priority and i_ret is ignored. The Stack never sees simultaneous push and pop.
- CALL_PUSH: o_push=1, o_push_data=ret_addr. On advance: depth+1, go to CALL_JUMP.
- CALL_JUMP: o_pc_load=1, o_pc_data=target. On advance: o_done=1 for the next enabled cycle, go to IDLE.
- RET_LOAD: o_pc_load=1, o_pc_data=i_stack_data (the current top of stack). On advance: go to RET_POP.
- RET_POP: o_pop=1. On advance: depth-1, o_done pulse, go to IDLE.
- o_done:
  - Registered; high exactly during the IDLE cycle following completion.
  - Cleared on the next clk_en edge.
- Latency at clk_en=1 every cycle: CALL and RET each occupy 2 busy cycles. A new request is accepted on the cycle o_done is high (back-to-back).
- Requests are ignored while o_busy=1; the requester holds its level until o_done.
- o_push_data and o_pc_data are 0 whenever their strobe is low.
- Flag clearing: i_clr_err=1 on a clk_en edge clears both sticky flags. If a new fault occurs on the same edge, the set wins.
- Depth bounds: depth never exceeds STACK_DEPTH and never goes below 0.
  - A full stack holds STACK_DEPTH entries; the Stack pointer wrap at full is legal.

Test Plan:
- Reset, then i_pc=0x0010, i_target=0x0200, i_call=1 -> CALL_PUSH with o_push=1 and o_push_data=0x0011; next cycle o_pc_load=1 and o_pc_data=0x0200; then o_done=1 and o_depth=1.
- After that CALL, i_ret=1 with i_stack_data=0x0011 -> o_pc_load=1 and o_pc_data=0x0011; next cycle o_pop=1; then o_done=1 and o_depth=0.
- 16 back-to-back CALLs, then a 17th -> o_depth=16; the 17th raises o_overflow with no o_push; i_clr_err=1 -> o_overflow=0.
- RET at depth 0 -> o_underflow=1, o_busy stays 0, no o_pc_load; i_call and i_ret together at depth 1 -> CALL is executed and o_pop never rises.
- Toggle clk_en 1/0 during a CALL -> state and strobes hold on disabled cycles; exactly one push per CALL; i_pc=0xFFFF gives o_push_data=0x0000.
- Assert rst during CALL_JUMP -> immediate IDLE, o_pc_load=0, o_depth=0, flags 0.
